// File: rtl/regfile_master_if.sv
// Command, write-data, read-response and register-file port bundle for regfile_master.
// The master modport is the burst engine's view; slave is the user/register-file side.
interface regfile_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    logic                  busy;

    logic [DATA_WIDTH-1:0] rf_wrdata;
    logic [ADDR_WIDTH-1:0] rf_address;
    logic                  rf_wren;
    logic                  rf_rden;
    logic [DATA_WIDTH-1:0] rf_rddata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rsp_valid, rsp_data, rsp_last,
        input  rsp_ready,
        output busy,
        output rf_wrdata, rf_address, rf_wren, rf_rden,
        input  rf_rddata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rsp_valid, rsp_data, rsp_last,
        output rsp_ready,
        input  busy,
        input  rf_wrdata, rf_address, rf_wren, rf_rden,
        output rf_rddata
    );
endinterface

// File: rtl/regfile_master.sv
// Burst engine that turns single write/read burst commands into beat-by-beat
// accesses on a synchronous-read register-file port, with wrapping addresses.
module regfile_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    regfile_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        RD_ISSUE,
        RD_CAPTURE,
        RSP_HOLD
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  last_beat;

    assign last_beat = (remaining == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_next = bus.cmd_write ? WR_BEAT : RD_ISSUE;
                end
            end
            WR_BEAT: begin
                if (bus.wr_valid && last_beat) begin
                    state_next = IDLE;
                end
            end
            RD_ISSUE:   state_next = RD_CAPTURE;
            RD_CAPTURE: state_next = RSP_HOLD;
            RSP_HOLD: begin
                if (bus.rsp_ready) begin
                    state_next = last_beat ? IDLE : RD_ISSUE;
                end
            end
            default:    state_next = IDLE;
        endcase
    end

    // Burst bookkeeping advances only on a completed beat handshake, so a
    // stalled writer or a back-pressuring reader freezes address and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            remaining  <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        cur_addr  <= bus.cmd_addr;
                        remaining <= bus.cmd_len;
                    end
                end
                WR_BEAT: begin
                    if (bus.wr_valid && !last_beat) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                    end
                end
                RD_CAPTURE: begin
                    rsp_data_q <= bus.rf_rddata;
                end
                RSP_HOLD: begin
                    if (bus.rsp_ready && !last_beat) begin
                        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                        remaining <= remaining - ADDR_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Write strobe follows wr_valid combinationally so the register file
    // commits on the same edge that completes the beat handshake.
    always_comb begin
        bus.cmd_ready  = 1'b0;
        bus.wr_ready   = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_last   = 1'b0;
        bus.rf_wren    = 1'b0;
        bus.rf_rden    = 1'b0;
        bus.rf_address = '0;
        bus.rf_wrdata  = '0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
            end
            WR_BEAT: begin
                bus.wr_ready   = 1'b1;
                bus.rf_wren    = bus.wr_valid;
                bus.rf_address = cur_addr;
                bus.rf_wrdata  = bus.wr_data;
            end
            RD_ISSUE: begin
                bus.rf_rden    = 1'b1;
                bus.rf_address = cur_addr;
            end
            RSP_HOLD: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = last_beat;
            end
            default: begin
            end
        endcase
    end

    assign bus.busy     = (state != IDLE);
    assign bus.rsp_data = rsp_data_q;

endmodule

// File: tb/tb_regfile_master.sv
// Directed bench for regfile_master: write/read bursts, wrap, stall,
// back-pressure and mid-burst reset against an 8x16 synchronous register file.
module tb_regfile_master;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   done;

    logic [15:0] mem [8];

    regfile_master_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    regfile_master #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: write on wren edge, read data valid the cycle after rden.
    always @(posedge clk) begin
        if (bus.rf_wren) mem[bus.rf_address] <= bus.rf_wrdata;
        if (bus.rf_rden) bus.rf_rddata <= mem[bus.rf_address];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            #2;
            checkOutput("rf_excl", 32'(bus.rf_wren && bus.rf_rden), 0);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit wr, input int addr, input int len);
        cyc();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = 3'(addr);
        bus.cmd_len   = 3'(len);
        bus.wr_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    endtask

    task automatic writeBeat(input string tag, input int data, input int ea);
        cyc();
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'(data);
        #1;
        checkOutput({tag, "_wr_ready"}, 32'(bus.wr_ready), 1);
        checkOutput({tag, "_wren"},     32'(bus.rf_wren), 1);
        checkOutput({tag, "_addr"},     32'(bus.rf_address), 32'(ea));
        checkOutput({tag, "_data"},     32'(bus.rf_wrdata), 32'(data));
        checkOutput({tag, "_cmd_rdy"},  32'(bus.cmd_ready), 0);
    endtask

    task automatic stallBeat(input string tag, input int ea);
        cyc();
        bus.wr_valid = 1'b0;
        #1;
        checkOutput({tag, "_wren"}, 32'(bus.rf_wren), 0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 1);
        checkOutput({tag, "_addr"}, 32'(bus.rf_address), 32'(ea));
    endtask

    task automatic readBeat(input string tag, input int ea, input int ed, input bit el, input int hold);
        cyc();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_rden"},   32'(bus.rf_rden), 1);
        checkOutput({tag, "_raddr"},  32'(bus.rf_address), 32'(ea));
        checkOutput({tag, "_nvalid"}, 32'(bus.rsp_valid), 0);
        cyc();
        #1;
        checkOutput({tag, "_cap_rden"},  32'(bus.rf_rden), 0);
        checkOutput({tag, "_cap_valid"}, 32'(bus.rsp_valid), 0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            bus.rsp_ready = 1'b0;
            #1;
            checkOutput({tag, "_bp_valid"}, 32'(bus.rsp_valid), 1);
            checkOutput({tag, "_bp_data"},  32'(bus.rsp_data), 32'(ed));
            checkOutput({tag, "_bp_rden"},  32'(bus.rf_rden), 0);
            checkOutput({tag, "_bp_cmdrdy"}, 32'(bus.cmd_ready), 0);
        end
        cyc();
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 1);
        checkOutput({tag, "_data"},  32'(bus.rsp_data), 32'(ed));
        checkOutput({tag, "_last"},  32'(bus.rsp_last), 32'(el));
    endtask

    task automatic expectIdle(input string tag);
        cyc();
        bus.cmd_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_busy"},    32'(bus.busy), 0);
        checkOutput({tag, "_cmd_rdy"}, 32'(bus.cmd_ready), 1);
        checkOutput({tag, "_wren"},    32'(bus.rf_wren), 0);
        checkOutput({tag, "_rden"},    32'(bus.rf_rden), 0);
        checkOutput({tag, "_valid"},   32'(bus.rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        done  = 1'b0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        checkOutput("rst_busy",      32'(bus.busy), 0);
        checkOutput("rst_wr_ready",  32'(bus.wr_ready), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("rst_rsp_data",  32'(bus.rsp_data), 0);
        checkOutput("rst_rsp_last",  32'(bus.rsp_last), 0);
        checkOutput("rst_rf_addr",   32'(bus.rf_address), 0);
        checkOutput("rst_rf_wrdata", 32'(bus.rf_wrdata), 0);
        checkOutput("rst_wren",      32'(bus.rf_wren), 0);
        checkOutput("rst_rden",      32'(bus.rf_rden), 0);

        // Stray write data and response-ready while idle must be ignored.
        cyc();
        bus.wr_valid  = 1'b1;
        bus.wr_data   = 16'd999;
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("idle_ignore_wren",  32'(bus.rf_wren), 0);
        checkOutput("idle_ignore_wrrdy", 32'(bus.wr_ready), 0);
        checkOutput("idle_ignore_busy",  32'(bus.busy), 0);

        applyStimulus(1'b1, 0, 2);
        writeBeat("w0", 50, 0);
        writeBeat("w1", 70, 1);
        writeBeat("w2", 20, 2);
        expectIdle("w_done");

        applyStimulus(1'b0, 0, 2);
        readBeat("r0", 0, 50, 1'b0, 0);
        readBeat("r1", 1, 70, 1'b0, 0);
        readBeat("r2", 2, 20, 1'b1, 0);
        expectIdle("r_done");

        applyStimulus(1'b1, 7, 1);
        writeBeat("wrap_w0", 1023, 7);
        writeBeat("wrap_w1", 65535, 0);
        expectIdle("wrap_w_done");
        applyStimulus(1'b0, 7, 1);
        readBeat("wrap_r0", 7, 1023, 1'b0, 0);
        readBeat("wrap_r1", 0, 65535, 1'b1, 0);
        expectIdle("wrap_r_done");

        applyStimulus(1'b1, 3, 2);
        writeBeat("st_w0", 11, 3);
        for (int i = 0; i < 4; i++) stallBeat("stall", 4);
        writeBeat("st_w1", 22, 4);
        writeBeat("st_w2", 33, 5);
        expectIdle("st_done");

        applyStimulus(1'b0, 3, 2);
        readBeat("bp_r0", 3, 11, 1'b0, 5);
        readBeat("bp_r1", 4, 22, 1'b0, 0);
        readBeat("bp_r2", 5, 33, 1'b1, 0);
        expectIdle("bp_done");

        // Abort a 4-beat read while the second beat is waiting in the hold state.
        applyStimulus(1'b0, 0, 3);
        readBeat("ab_r0", 0, 65535, 1'b0, 0);
        cyc();
        bus.rsp_ready = 1'b0;
        #1;
        checkOutput("ab_r1_rden", 32'(bus.rf_rden), 1);
        checkOutput("ab_r1_addr", 32'(bus.rf_address), 1);
        cyc();
        #1;
        cyc();
        rst = 1'b1;
        #1;
        checkOutput("ab_hold_valid", 32'(bus.rsp_valid), 1);
        checkOutput("ab_hold_data",  32'(bus.rsp_data), 70);
        cyc();
        rst = 1'b0;
        #1;
        checkOutput("ab_busy",      32'(bus.busy), 0);
        checkOutput("ab_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("ab_cmd_ready", 32'(bus.cmd_ready), 1);
        checkOutput("ab_rsp_data",  32'(bus.rsp_data), 0);
        expectIdle("ab_quiet0");
        expectIdle("ab_quiet1");

        applyStimulus(1'b0, 2, 0);
        readBeat("post_r0", 2, 20, 1'b1, 0);
        expectIdle("post_done");

        done = 1'b1;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
